// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO plus load sequencer feeding a UART transmitter. Producers push
// bytes at up to one per cycle; the sequencer pops one byte at a time and
// strobes ld_tx_data only while the transmitter reports tx_empty.
//
// Ports:
//   txclk      - clock, all state changes on its rising edge
//   reset      - asynchronous active-low reset
//   wr_en      - push request
//   wr_data    - byte to push
//   flush      - synchronous clear of stored bytes (pointers and count)
//   full       - FIFO holds DEPTH bytes
//   empty      - FIFO holds no bytes
//   count      - number of bytes stored (0..DEPTH)
//   overflow   - sticky flag: a push was dropped while full
//   ld_tx_data - one-cycle load strobe to the transmitter
//   tx_data    - byte presented to the transmitter, held between pops
//   tx_empty   - transmitter idle and ready for a byte
//   busy       - sequencer not in IDLE
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          txclk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          ld_tx_data,
  output logic [7:0]    tx_data,
  input  logic          tx_empty,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            r_overflow;
  logic [7:0]      r_tx_data;
  logic            w_push;
  logic            w_pop;

  assign full     = (r_count == (AW+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign overflow = r_overflow;
  assign tx_data  = r_tx_data;

  // full is taken from the registered count, so a pop on the same edge
  // cannot make room for a push.
  assign w_push = wr_en && !full && !flush;
  assign w_pop  = (r_state == S_IDLE) && !empty && tx_empty && !flush;

  // NOTE: storage has no reset; contents are only meaningful between the
  // pointers, so clearing the array would cost logic and buy nothing.
  always_ff @(posedge txclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      if (wr_en && full) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_tx_data <= r_mem[r_rptr];
      end
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge txclk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  // NOTE: default assignment first so no path leaves the output unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_pop)     w_next_state = S_LOAD;
      S_LOAD:                     w_next_state = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!tx_empty) w_next_state = S_WAIT_DONE;
      S_WAIT_DONE: if (tx_empty)  w_next_state = S_IDLE;
      default:                    w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so they are glitch-free relative to
  // input changes and return to idle values as soon as reset asserts.
  always_comb begin
    ld_tx_data = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE:  busy       = 1'b0;
      S_LOAD:  ld_tx_data = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo with a transmitter model and a byte
// scoreboard: every accepted push queues its byte, every load strobe pops and
// compares the byte on tx_data.
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          txclk;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          ld_tx_data;
  logic [7:0]    tx_data;
  logic          tx_empty;
  logic          busy;

  int        n_vec     = 0;
  int        n_err     = 0;
  int        n_strobe  = 0;
  int        busy_cnt  = 0;
  int        frame_len = 20;
  int        cyc       = 0;
  int        rise_cyc  = -1000;
  bit        prev_te   = 1'b0;
  bit        in_frame  = 1'b0;
  bit        ld_prev   = 1'b0;
  bit        tx_hold   = 1'b0;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .txclk      (txclk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .flush      (flush),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .ld_tx_data (ld_tx_data),
    .tx_data    (tx_data),
    .tx_empty   (tx_empty),
    .busy       (busy)
  );

  initial txclk = 1'b0;
  always #5 txclk = ~txclk;

  // Transmitter model: busy for frame_len cycles after each strobe; tx_hold
  // forces it to report not-empty.
  assign tx_empty = (busy_cnt == 0) && !tx_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edge bookkeeping: tx_empty as seen by each rising edge, and the edge at
  // which the transmitter finished its last frame.
  always @(posedge txclk) begin
    cyc = cyc + 1;
    if (tx_empty && !prev_te && in_frame) begin
      rise_cyc = cyc;
      in_frame = 1'b0;
    end
    prev_te = tx_empty;
  end

  // Strobe monitor and scoreboard consumer.
  always @(negedge txclk) begin
    if (!reset) begin
      busy_cnt = 0;
      ld_prev  = 1'b0;
      in_frame = 1'b0;
    end else begin
      if (ld_tx_data) begin
        n_strobe++;
        check("strobe_one_cycle", 32'(ld_prev), 32'd0);
        check("strobe_tx_empty_at_edge", 32'(prev_te), 32'd1);
        check("strobe_gap", 32'(cyc - rise_cyc >= 1), 32'd1);
        check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("strobe_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        busy_cnt = frame_len;
        in_frame = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      ld_prev = ld_tx_data;
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge txclk);
      if (!busy && exp_q.size() == 0 && tx_empty) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"},    32'(count),      32'd0);
    check({tag, "_empty"},    32'(empty),      32'd1);
    check({tag, "_full"},     32'(full),       32'd0);
    check({tag, "_overflow"}, 32'(overflow),   32'd0);
    check({tag, "_ld"},       32'(ld_tx_data), 32'd0);
    check({tag, "_tx_data"},  32'(tx_data),    32'h00);
    check({tag, "_busy"},     32'(busy),       32'd0);
  endtask

  initial begin
    int base;
    bit drained;

    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    flush   = 1'b0;

    // Reset state.
    repeat (2) @(negedge txclk);
    check_reset_values("reset");
    reset = 1'b1;

    // Single byte: strobe one cycle after the push edge.
    frame_len = 20;
    wr_en = 1'b1; wr_data = 8'hAA; exp_q.push_back(8'hAA);
    @(negedge txclk);
    wr_en = 1'b0;
    check("single_count_after_push", 32'(count), 32'd1);
    check("single_no_early_strobe", 32'(ld_tx_data), 32'd0);
    @(negedge txclk);
    check("single_strobe", 32'(ld_tx_data), 32'd1);
    check("single_tx_data", 32'(tx_data), 32'hAA);
    check("single_count_after_pop", 32'(count), 32'd0);
    @(negedge txclk);
    check("single_strobe_ends", 32'(ld_tx_data), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    wait_idle(200, "single_drain");

    // Three back-to-back bytes with long frames.
    frame_len = 640;
    base = n_strobe;
    wr_en = 1'b1; wr_data = 8'hAA; exp_q.push_back(8'hAA);
    @(negedge txclk);
    wr_data = 8'hB4; exp_q.push_back(8'hB4);
    @(negedge txclk);
    wr_data = 8'hBE; exp_q.push_back(8'hBE);
    @(negedge txclk);
    wr_en = 1'b0;
    wait_idle(2500, "b2b_drain");
    check("b2b_strobe_count", 32'(n_strobe - base), 32'd3);

    // Overflow: nine pushes into an eight-entry FIFO while the transmitter is busy.
    frame_len = 20;
    tx_hold = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      if (i <= DEPTH) exp_q.push_back(8'(i));
      @(negedge txclk);
      if (i == DEPTH) begin
        check("ovf_full_at_8", 32'(full), 32'd1);
        check("ovf_count_at_8", 32'(count), 32'd8);
        check("ovf_flag_clear_at_8", 32'(overflow), 32'd0);
      end
    end
    wr_en = 1'b0;
    check("ovf_flag_set", 32'(overflow), 32'd1);
    check("ovf_count_held", 32'(count), 32'd8);
    check("ovf_full_held", 32'(full), 32'd1);
    check("ovf_no_pop_while_tx_busy", 32'(busy), 32'd0);
    tx_hold = 1'b0;
    wait_idle(400, "ovf_drain");
    check("ovf_drain_count", 32'(count), 32'd0);
    check("ovf_drain_empty", 32'(empty), 32'd1);

    // Push on the pop cycle while full is dropped; push+pop when not full holds count.
    tx_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h10 + 8'(i);
      exp_q.push_back(8'h10 + 8'(i));
      @(negedge txclk);
    end
    check("popfull_full", 32'(full), 32'd1);
    tx_hold = 1'b0;
    wr_data = 8'h55;
    @(negedge txclk);
    wr_en = 1'b0;
    tx_hold = 1'b1;
    check("popfull_count", 32'(count), 32'd7);
    check("popfull_not_full", 32'(full), 32'd0);
    check("popfull_tx_data", 32'(tx_data), 32'h10);
    drained = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge txclk);
      if (busy_cnt == 0) begin
        drained = 1'b1;
        break;
      end
    end
    check("popfull_frame_timeout", 32'(drained), 32'd1);
    check("popfull_waiting", 32'(busy), 32'd1);
    tx_hold = 1'b0;
    @(negedge txclk);
    wr_en = 1'b1; wr_data = 8'h66; exp_q.push_back(8'h66);
    @(negedge txclk);
    wr_en = 1'b0;
    check("pushpop_strobe", 32'(ld_tx_data), 32'd1);
    check("pushpop_count", 32'(count), 32'd7);
    wait_idle(600, "pushpop_drain");

    // Flush during WAIT_DONE with five bytes stored.
    frame_len = 40;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h21 + 8'(i);
      exp_q.push_back(8'h21 + 8'(i));
      @(negedge txclk);
    end
    check("flush_pre_count", 32'(count), 32'd5);
    check("flush_pre_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    wr_data = 8'h77;
    @(negedge txclk);
    flush = 1'b0;
    wr_en = 1'b0;
    exp_q.delete();
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_frame_continues", 32'(busy), 32'd1);
    check("flush_tx_data_held", 32'(tx_data), 32'h21);
    base = n_strobe;
    wait_idle(200, "flush_drain");
    check("flush_no_more_strobes", 32'(n_strobe - base), 32'd0);

    // Asynchronous reset mid-frame with bytes stored and overflow set.
    frame_len = 640;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = 8'hC0 + 8'(i);
      exp_q.push_back(8'hC0 + 8'(i));
      @(negedge txclk);
    end
    wr_en = 1'b0;
    repeat (6) @(negedge txclk);
    check("rstmid_pre_busy", 32'(busy), 32'd1);
    check("rstmid_pre_count", 32'(count), 32'd2);
    check("rstmid_pre_overflow", 32'(overflow), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("rstmid");
    exp_q.delete();
    @(negedge txclk);
    reset = 1'b1;
    base = n_strobe;
    repeat (20) @(negedge txclk);
    check("rstmid_no_strobe", 32'(n_strobe - base), 32'd0);
    check("rstmid_idle", 32'(busy), 32'd0);
    check("rstmid_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
